switch_conditioner: RTL and testbench
=====================================

# switch_conditioner

Parametrised switch front end: each of `NUM_SWITCHES` asynchronous switch inputs passes through a multi-stage synchronizer and a per-channel debounce counter. The block outputs a clean level per channel and single-cycle press/release strobes. It sits between the board switch pins and all consuming logic, so downstream modules no longer debounce or edge-detect on their own.

## Interface
Parameters:
- `NUM_SWITCHES`, default 4: channel count; ≥1.
- `SYNC_STAGES`, default 2: synchronizer flop depth per channel; ≥2.
- `DEBOUNCE_CYCLES`, default 250000: consecutive stable cycles required before a level change is accepted; ≥1. The default is 10 ms at 25 MHz.
- `RESET_LEVEL`, default 1'b0: value loaded into every synchronizer flop and every debounced level on reset.

Ports:
- `i_clk`, input, 1: the single clock. All logic is on its rising edge.
- `i_reset`, input, 1: synchronous, active-high reset.
- `i_switches`, input, `NUM_SWITCHES`: raw asynchronous switch pins.
- `o_switches`, output, `NUM_SWITCHES`: debounced, registered level per channel.
- `o_pressed`, output, `NUM_SWITCHES`: one-cycle strobe when a debounced level goes 0→1.
- `o_released`, output, `NUM_SWITCHES`: one-cycle strobe when a debounced level goes 1→0.

## Operation
Each channel n is fully independent. There is no shared state except clock and reset.

- **Synchronizer:** a chain of `SYNC_STAGES` flops. `sync[n]` is the last stage. No logic is placed between the stages.
- **Counter:** width is `$clog2(DEBOUNCE_CYCLES+1)`, minimum 1 bit. Per channel, each edge does the following:
  - If `sync[n] == o_switches[n]`: counter ← 0. No change.
  - If they differ and counter < `DEBOUNCE_CYCLES-1`: counter ← counter+1.
  - If they differ and counter == `DEBOUNCE_CYCLES-1`:
    - `o_switches[n]` ← `sync[n]` and counter ← 0.
    - `o_pressed[n]` ← `sync[n]` and `o_released[n]` ← `~sync[n]`.
- **Strobes:** `o_pressed[n]` and `o_released[n]` are registered and high for exactly one cycle. That cycle is the first cycle in which `o_switches[n]` shows the new level. Otherwise both are 0, and they are never high together.
- **Glitches:** any return of `sync[n]` to the current debounced level clears the counter. A pulse or bounce shorter than `DEBOUNCE_CYCLES` cycles at `sync[n]` therefore produces no output change and no strobe.
- **Counter range:** the counter never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Reset** (any cycle, including mid-count), which takes priority over everything else:
  - All synchronizer flops and `o_switches` are set to `RESET_LEVEL`.
  - All counters are set to 0.
  - `o_pressed` and `o_released` are set to 0.
  - Any count in progress is discarded.
- **After reset:** if a pin sits at a level different from `RESET_LEVEL`, it is treated as a genuine change. The full latency applies and the normal strobe is emitted.

## Timing
- **Reset values:** `o_switches` = {NUM_SWITCHES{RESET_LEVEL}}, `o_pressed` = 0, `o_released` = 0. These are visible in the cycle after the reset edge.
- **Latency** for an input that changes and stays put:
  - Count the first rising edge sampling the new level as edge 1.
  - `sync[n]` shows the new level after edge `SYNC_STAGES`.
  - `o_switches[n]` and its strobe update on edge `SYNC_STAGES + DEBOUNCE_CYCLES`.
  - Minimum latency, with `DEBOUNCE_CYCLES`=1, is `SYNC_STAGES+1` edges.
- **Re-arming:** after an accepted change, a change in the opposite direction needs a further full `DEBOUNCE_CYCLES` stable cycles at `sync[n]`. The earliest opposite strobe is `DEBOUNCE_CYCLES` cycles after the previous one.
- **Simultaneous events:** several channels may strobe in the same cycle.

## Test plan
Bench parameters: `NUM_SWITCHES`=4, `SYNC_STAGES`=2, `DEBOUNCE_CYCLES`=4, `RESET_LEVEL`=0.

1. **Reset.** Assert `i_reset` for 2 cycles with `i_switches`=4'b0000. Then `o_switches`=0, `o_pressed`=0, `o_released`=0, and all remain 0 for 20 cycles.
2. **Clean press and release.** Step `i_switches[0]` to 1 before edge 1 and hold.
   - `o_switches[0]` goes 1 on edge 6. `o_pressed`=4'b0001 for exactly that one cycle.
   - Drop the input 10 cycles later. `o_switches[0]` goes 0 six edges after the drop. `o_released`=4'b0001 for one cycle.
3. **Bounce rejection.** On channel 1, drive 1 for 3 cycles, then 0 for 1 cycle, repeated 5 times.
   - Result: no change on `o_switches[1]` and no strobes.
   - Then hold 1 for 8 cycles: exactly one `o_pressed[1]` strobe.
4. **Simultaneous channels.** Step `i_switches` from 4'b0000 to 4'b1010 before one edge.
   - `o_switches`=4'b1010 and `o_pressed`=4'b1010 on the same edge 6. `o_released`=0.
5. **Reset mid-count.** Step channel 2 high. Assert `i_reset` on edge 4, before acceptance.
   - `o_switches[2]`=0 and no strobe around the reset.
   - With the input still high, the press is accepted 6 edges after reset deassertion.
6. **Non-default reset level.** Re-elaborate with `RESET_LEVEL`=1 and pins held at 4'b1111 through reset.
   - No strobes ever occur.
   - Dropping channel 3 gives `o_released`=4'b1000 for one cycle, six edges later.

Source files
------------

// File: rtl/switch_conditioner.sv
// Switch front end: per-channel synchronizer and debounce counter producing a clean level plus press/release strobes.
// Accepted level and strobes appear SYNC_STAGES + DEBOUNCE_CYCLES edges after a stable input change.
module switch_conditioner #(
  parameter int   NUM_SWITCHES    = 4,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 250000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [NUM_SWITCHES-1:0] i_switches,
  output logic [NUM_SWITCHES-1:0] o_switches,
  output logic [NUM_SWITCHES-1:0] o_pressed,
  output logic [NUM_SWITCHES-1:0] o_released
);

  localparam int CNT_W = ($clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_SWITCHES-1:0] stages [SYNC_STAGES];
  logic [NUM_SWITCHES-1:0] sync;
  logic [CNT_W-1:0]        count  [NUM_SWITCHES];

  assign sync = stages[SYNC_STAGES-1];

  // Plain flop chain: nothing may sit between stages.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        stages[s] <= {NUM_SWITCHES{RESET_LEVEL}};
      end
    end else begin
      stages[0] <= i_switches;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        stages[s] <= stages[s-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_switches <= {NUM_SWITCHES{RESET_LEVEL}};
      o_pressed  <= '0;
      o_released <= '0;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        count[n] <= '0;
      end
    end else begin
      o_pressed  <= '0;
      o_released <= '0;
      for (int n = 0; n < NUM_SWITCHES; n++) begin
        if (sync[n] == o_switches[n]) begin
          count[n] <= '0;
        end else if (count[n] == CNT_LAST) begin
          // Strobe lands in the same cycle the new level first shows.
          o_switches[n] <= sync[n];
          o_pressed[n]  <= sync[n];
          o_released[n] <= ~sync[n];
          count[n]      <= '0;
        end else begin
          count[n] <= count[n] + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_switch_conditioner.sv
// Bench for switch_conditioner: directed scenarios plus random toggling, checked against a window-based model.
module tb_switch_conditioner;

  localparam int S    = 2;
  localparam int DC   = 4;
  localparam int MAXE = 8192;

  logic       clk = 1'b0;
  logic [1:0] rst;
  logic [3:0] sw    [2];
  logic [3:0] o_sw  [2];
  logic [3:0] o_pr  [2];
  logic [3:0] o_rel [2];

  int errors = 0;
  int checks = 0;
  bit armed  = 1'b0;

  always #5 clk = ~clk;

  switch_conditioner #(
    .NUM_SWITCHES(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .RESET_LEVEL(1'b0)
  ) dut0 (
    .i_clk(clk), .i_reset(rst[0]), .i_switches(sw[0]),
    .o_switches(o_sw[0]), .o_pressed(o_pr[0]), .o_released(o_rel[0])
  );

  switch_conditioner #(
    .NUM_SWITCHES(4), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(DC), .RESET_LEVEL(1'b1)
  ) dut1 (
    .i_clk(clk), .i_reset(rst[1]), .i_switches(sw[1]),
    .o_switches(o_sw[1]), .o_pressed(o_pr[1]), .o_released(o_rel[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Model: a channel takes level v at edge e when the synchronized input
  // (raw sample from S edges earlier, or the reset level if that predates
  // the last reset) has equalled v, unlike the current level, for DC edges.
  logic [3:0] hist [2][MAXE];
  int         e = 0;
  int         last_rst [2] = '{0, 0};
  logic [3:0] m_lvl [2];
  logic [3:0] m_prs [2];
  logic [3:0] m_rel [2];

  function automatic logic eff(input int k, input int idx, input int ch);
    if (idx <= last_rst[k]) return (k == 1);
    return hist[k][idx][ch];
  endfunction

  always @(posedge clk) begin
    if (e < MAXE - 1) e = e + 1;
    for (int k = 0; k < 2; k++) begin
      hist[k][e] = sw[k];
      m_prs[k] = 4'h0;
      m_rel[k] = 4'h0;
      if (rst[k]) begin
        last_rst[k] = e;
        m_lvl[k]    = (k == 1) ? 4'hF : 4'h0;
      end else begin
        for (int ch = 0; ch < 4; ch++) begin
          logic v;
          bit   ok;
          v  = eff(k, e - S, ch);
          ok = (v != m_lvl[k][ch]);
          for (int j = 0; j < DC; j++)
            if (eff(k, e - S - j, ch) != v) ok = 0;
          if (ok) begin
            m_lvl[k][ch] = v;
            m_prs[k][ch] = v;
            m_rel[k][ch] = ~v;
          end
        end
      end
    end
  end

  int pcnt [2][4];
  int rcnt [2][4];
  initial for (int k = 0; k < 2; k++) for (int c = 0; c < 4; c++) begin pcnt[k][c] = 0; rcnt[k][c] = 0; end

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("model_inst%0d", k), {20'h0, o_sw[k], o_pr[k], o_rel[k]},
              {20'h0, m_lvl[k], m_prs[k], m_rel[k]});
        for (int c = 0; c < 4; c++) begin
          pcnt[k][c] += int'(o_pr[k][c]);
          rcnt[k][c] += int'(o_rel[k][c]);
        end
      end
    end
  end

  initial begin
    int p0;
    rst   = 2'b11;
    sw[0] = 4'h0;
    sw[1] = 4'hF;
    step(2);
    rst   = 2'b00;
    armed = 1'b1;
    check("rst_sw0", o_sw[0], 4'h0);
    check("rst_pr0", o_pr[0], 4'h0);
    check("rst_rel0", o_rel[0], 4'h0);
    check("rst_sw1", o_sw[1], 4'hF);
    for (int i = 0; i < 20; i++) begin
      step(1);
      check("rst_quiet", {o_sw[0], o_pr[0], o_rel[0]}, 12'h0);
    end

    // Clean press and release on channel 0
    sw[0][0] = 1'b1;
    step(5);  check("press_early", o_sw[0], 4'h0);
    step(1);  check("press_sw", o_sw[0], 4'h1);
              check("press_strobe", o_pr[0], 4'h1);
    step(1);  check("press_one_cycle", o_pr[0], 4'h0);
    step(8);
    sw[0][0] = 1'b0;
    step(5);  check("rel_early", o_sw[0], 4'h1);
    step(1);  check("rel_sw", o_sw[0], 4'h0);
              check("rel_strobe", o_rel[0], 4'h1);
    step(1);  check("rel_one_cycle", o_rel[0], 4'h0);

    // Bounce rejection on channel 1
    p0 = pcnt[0][1];
    for (int i = 0; i < 5; i++) begin
      sw[0][1] = 1'b1; step(3);
      sw[0][1] = 1'b0; step(1);
    end
    check("bounce_no_press", pcnt[0][1] - p0, 0);
    check("bounce_level", o_sw[0][1], 1'b0);
    sw[0][1] = 1'b1;
    step(8);
    check("bounce_then_hold", pcnt[0][1] - p0, 1);
    check("hold_level", o_sw[0][1], 1'b1);
    sw[0][1] = 1'b0;
    step(10);
    check("ch1_back_low", o_sw[0], 4'h0);

    // Simultaneous channels
    sw[0] = 4'b1010;
    step(5);  check("simul_early", o_sw[0], 4'h0);
    step(1);  check("simul_sw", o_sw[0], 4'b1010);
              check("simul_pr", o_pr[0], 4'b1010);
              check("simul_rel", o_rel[0], 4'h0);
    sw[0] = 4'h0;
    step(10);

    // Reset mid-count on channel 2
    p0 = pcnt[0][2];
    sw[0] = 4'b0100;
    step(3);
    rst[0] = 1'b1;
    step(1);
    check("midrst_sw", o_sw[0], 4'h0);
    check("midrst_pr", o_pr[0], 4'h0);
    rst[0] = 1'b0;
    step(5);  check("midrst_early", o_sw[0], 4'h0);
              check("midrst_no_strobe", pcnt[0][2] - p0, 0);
    step(1);  check("midrst_pr_after", o_pr[0], 4'b0100);
              check("midrst_sw_after", o_sw[0], 4'b0100);
    sw[0] = 4'h0;
    step(10);

    // Non-default reset level instance
    check("rl1_no_press", pcnt[1][0] + pcnt[1][1] + pcnt[1][2] + pcnt[1][3], 0);
    check("rl1_no_rel", rcnt[1][0] + rcnt[1][1] + rcnt[1][2] + rcnt[1][3], 0);
    check("rl1_level", o_sw[1], 4'hF);
    sw[1] = 4'b0111;
    step(5);  check("rl1_rel_early", o_rel[1], 4'h0);
    step(1);  check("rl1_rel", o_rel[1], 4'b1000);
              check("rl1_sw", o_sw[1], 4'b0111);
    step(1);  check("rl1_rel_one", o_rel[1], 4'h0);
    check("rl1_never_press", pcnt[1][0] + pcnt[1][1] + pcnt[1][2] + pcnt[1][3], 0);

    // Random toggling with occasional resets
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++)
          if ($urandom_range(0, 5) == 0) sw[k][c] = ~sw[k][c];
        rst[k] = ($urandom_range(0, 299) == 0);
      end
      step(1);
    end
    rst = 2'b00;
    step(10);

    armed = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
